// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Byte-stream program loader for the LC3 memory write port.
//               Frame: ADDR_HI ADDR_LO LEN_HI LEN_LO then LEN big-endian
//               16-bit words written to consecutive addresses.
//               Optional macro LOADER_VERIFY_EN adds a read-back VERIFY
//               cycle after every performed write.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_loader #(
  parameter int N_ELEMENTS = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] words_written
);

  // One extra bit so N_ELEMENTS = 2^ADDR_WIDTH would still be representable.
  localparam logic [ADDR_WIDTH:0]   c_N_LIMIT = (ADDR_WIDTH+1)'(N_ELEMENTS);
  localparam logic [ADDR_WIDTH-1:0] c_ONE     = ADDR_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR_HI = 4'd1,
    S_ADDR_LO = 4'd2,
    S_LEN_HI  = 4'd3,
    S_LEN_LO  = 4'd4,
    S_DATA_HI = 4'd5,
    S_DATA_LO = 4'd6,
    S_WRITE   = 4'd7,
    S_VERIFY  = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  state_t                r_state;
  logic [7:0]            r_hi_byte;     // high byte of the field being assembled
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [ADDR_WIDTH-1:0] r_remaining;
  logic                  r_in_ready;
  logic [ADDR_WIDTH-1:0] r_w_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic                  r_w_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_words;

  logic                  w_accept;
  logic [15:0]           w_field;
  logic [ADDR_WIDTH-1:0] w_field_a;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_in_range;

  // Byte handshake and field assembly from the stored high byte plus current byte.
  assign w_accept   = in_valid & r_in_ready;
  assign w_field    = {r_hi_byte, in_data};
  assign w_field_a  = ADDR_WIDTH'(w_field);
  assign w_word     = DATA_WIDTH'(w_field);
  assign w_in_range = ({1'b0, r_cur_addr} < c_N_LIMIT);

`ifdef LOADER_VERIFY_EN
  logic [ADDR_WIDTH-1:0] r_r_addr;
  assign r_addr = r_r_addr;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^r_data;
  assign r_addr = '0;
`endif

  // Loader FSM: header parse, word assembly, write strobe and optional read-back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_hi_byte   <= '0;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_in_ready  <= 1'b0;
      r_w_addr    <= '0;
      r_w_data    <= '0;
      r_w_en      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_words     <= '0;
`ifdef LOADER_VERIFY_EN
      r_r_addr    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_ADDR_HI;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_words    <= '0;
          end
        end
        S_ADDR_HI: begin
          if (w_accept) begin
            r_hi_byte <= in_data;
            r_state   <= S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          if (w_accept) begin
            r_cur_addr <= w_field_a;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_hi_byte <= in_data;
            r_state   <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_remaining <= w_field_a;
            if (w_field_a == '0) begin
              // Empty image: finish without touching memory.
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (w_accept) begin
            r_hi_byte <= in_data;
            r_state   <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (w_accept) begin
            // The write strobe is registered here so it is visible during WRITE,
            // exactly one cycle after the low-byte handshake.
            r_state     <= S_WRITE;
            r_in_ready  <= 1'b0;
            r_cur_addr  <= r_cur_addr + c_ONE;
            r_remaining <= r_remaining - c_ONE;
            if (w_in_range) begin
              r_w_en   <= 1'b1;
              r_w_addr <= r_cur_addr;
              r_w_data <= w_word;
              r_words  <= r_words + c_ONE;
            end else begin
              // Out-of-range word is consumed to keep framing, but flagged.
              r_err <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_w_en <= 1'b0;
`ifdef LOADER_VERIFY_EN
          if (r_w_en) begin
            r_state  <= S_VERIFY;
            r_r_addr <= r_w_addr;
          end else
`endif
          if (r_remaining == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_DATA_HI;
            r_in_ready <= 1'b1;
          end
        end
`ifdef LOADER_VERIFY_EN
        S_VERIFY: begin
          // Memory read is asynchronous and the write landed at the end of WRITE.
          if (r_data != r_w_data) begin
            r_err <= 1'b1;
          end
          if (r_remaining == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_DATA_HI;
            r_in_ready <= 1'b1;
          end
        end
`endif
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_w_en     <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign w_addr        = r_w_addr;
  assign w_data        = r_w_data;
  assign w_en          = r_w_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign words_written = r_words;

endmodule
`default_nettype wire

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Byte-stream program loader that drives the write port of the LC3 data/instruction memory (w_addr/w_data/w_en).
- Parses a framed image (start address, word count, big-endian 16-bit words) from a valid/ready byte channel and writes each word into consecutive memory locations.
- Sits between the host/UART receive path and the memory. Replaces compile-time image initialization with a runtime load.

Parameters:
- N_ELEMENTS, 128, number of memory words; addresses >= N_ELEMENTS are out of range.
- ADDR_WIDTH, 16, width of memory address and word counter.
- DATA_WIDTH, 16, memory word width. Must be 16 (two bytes per word).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- start  input  1  single-cycle pulse that arms a load. Honoured only in IDLE or DONE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte. Transfer occurs when in_valid && in_ready.
- w_addr  output  ADDR_WIDTH  memory write address.
- w_data  output  DATA_WIDTH  memory write data.
- w_en  output  1  memory write enable, single-cycle pulse.
- r_addr  output  ADDR_WIDTH  memory read address. Used only with LOADER_VERIFY_EN; tied to 0 otherwise.
- r_data  input  DATA_WIDTH  memory read data (asynchronous read). Ignored without LOADER_VERIFY_EN.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  high in DONE.
- err  output  1  sticky error; cleared by reset or accepted start.
- words_written  output  ADDR_WIDTH  count of w_en pulses this load.

Behaviour:
- Reset (rst=0 at posedge): state IDLE. All outputs 0, all internal registers 0.
- Reset mid-load aborts with no further writes.
- States: IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, VERIFY (macro only), DONE.
- in_ready = 1 only in ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA_HI, DATA_LO. It is a registered function of state and does not depend on in_valid.
- IDLE/DONE + start: go to ADDR_HI. Clear err, words_written, done.
- start in any other state: ignored.
- The header and data states each advance one state per accepted byte. The high byte is received first.
  - ADDR_HI/ADDR_LO load cur_addr.
  - LEN_HI/LEN_LO load remaining.
- LEN_LO accepted with length 0: go to DONE. No writes.
- LEN_LO accepted with length nonzero: go to DATA_HI.
- DATA_HI: latch byte into data[15:8].
- DATA_LO: latch byte into data[7:0]. Next cycle enters WRITE.
- WRITE (one cycle, in_ready=0):
  - w_addr=cur_addr, w_data=assembled word.
  - w_en=1 if cur_addr < N_ELEMENTS. Otherwise w_en=0 and err set.
  - words_written increments only on an actual write.
  - cur_addr increments and wraps modulo 2^ADDR_WIDTH.
  - remaining decrements.
  - Next state: DONE if remaining was 1, else DATA_HI (or VERIFY under the macro).
- Latency: w_en is asserted exactly 1 cycle after the DATA_LO handshake. Throughput is one word per 3 cycles minimum.
- Out-of-range words are still consumed so stream framing is preserved.
- The word count equal to 2^ADDR_WIDTH-1 is legal.
- w_addr/w_data hold their last value when w_en=0. Reset value is 0.
- DONE: done=1 and busy=0. Remains in DONE until start or reset.
- Stalls: in_valid low holds state indefinitely with no timeout.

Optional Feature:
- Macro LOADER_VERIFY_EN.
- When defined:
  - After each WRITE that performed a write, enter VERIFY for one cycle.
  - r_addr = address just written.
  - Compare r_data against the written word. On mismatch set err.
  - Then go to DONE or DATA_HI per remaining.
  - WRITE cycles with no write skip VERIFY.
  - Throughput: 4 cycles per word.
- When undefined:
  - VERIFY is absent, r_addr is constant 0, r_data is unused.
  - Timing is as in Behaviour.

Test Plan:
- rst=0 for 2 cycles, then 1 → all outputs 0, state IDLE. start → in_ready=1 next cycle, busy=1.
- start; stream 00 10 00 03 12 34 AB CD 00 01 → w_en pulses at addrs 0x10/0x11/0x12 with data 0x1234/0xABCD/0x0001, each 1 cycle after its low byte. done=1, words_written=3, err=0.
- Header 00 7F 00 02, data 11 11 22 22 → write 0x1111 at 0x7F only. Second word gives w_en=0 and err=1. words_written=1, done=1.
- Header 00 05 00 00 → no w_en, done=1 the cycle after LEN_LO, in_ready=0.
- Random in_valid gaps during a 4-word load → identical writes and order. No byte is accepted while in_ready=0. start pulsed mid-load is ignored.
- rst=0 asserted after DATA_HI of word 2 → no further w_en, outputs 0. A new start reloads cleanly. With LOADER_VERIFY_EN and a memory model forced to corrupt addr 0x10 → err=1 after its VERIFY cycle.
